// File: rtl/morse_pkg.sv
// Shared types, character codes and the Morse pattern decoder for morse_sequencer.
package morse_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP, ST_COMMIT} morse_state_e;

  localparam logic [5:0] CODE_NONE = 6'b111111;

  localparam logic [5:0] CODE_0 = 6'd0, CODE_1 = 6'd1, CODE_2 = 6'd2, CODE_3 = 6'd3,
                         CODE_4 = 6'd4, CODE_5 = 6'd5, CODE_6 = 6'd6, CODE_7 = 6'd7,
                         CODE_8 = 6'd8, CODE_9 = 6'd9;

  localparam logic [5:0] CODE_A = 6'd10, CODE_B = 6'd11, CODE_C = 6'd12, CODE_D = 6'd13,
                         CODE_E = 6'd14, CODE_F = 6'd15, CODE_G = 6'd16, CODE_H = 6'd17,
                         CODE_I = 6'd18, CODE_J = 6'd19, CODE_K = 6'd20, CODE_L = 6'd21,
                         CODE_M = 6'd22, CODE_N = 6'd23, CODE_O = 6'd24, CODE_P = 6'd25,
                         CODE_Q = 6'd26, CODE_R = 6'd27, CODE_S = 6'd28, CODE_T = 6'd29,
                         CODE_U = 6'd30, CODE_V = 6'd31, CODE_W = 6'd32, CODE_X = 6'd33,
                         CODE_Y = 6'd34, CODE_Z = 6'd35;

  // bits are right-aligned: the first element keyed sits at bit len-1, 1 = dash
  function automatic logic [5:0] morse_decode(input logic [2:0] len, input logic [4:0] bits);
    logic [5:0] code;
    code = CODE_NONE;
    case (len)
      3'd1: code = bits[0] ? CODE_T : CODE_E;
      3'd2:
        case (bits[1:0])
          2'b00: code = CODE_I;
          2'b01: code = CODE_A;
          2'b10: code = CODE_N;
          default: code = CODE_M;
        endcase
      3'd3:
        case (bits[2:0])
          3'b000: code = CODE_S;
          3'b001: code = CODE_U;
          3'b010: code = CODE_R;
          3'b011: code = CODE_W;
          3'b100: code = CODE_D;
          3'b101: code = CODE_K;
          3'b110: code = CODE_G;
          default: code = CODE_O;
        endcase
      3'd4:
        case (bits[3:0])
          4'b0000: code = CODE_H;
          4'b0001: code = CODE_V;
          4'b0010: code = CODE_F;
          4'b0100: code = CODE_L;
          4'b0110: code = CODE_P;
          4'b0111: code = CODE_J;
          4'b1000: code = CODE_B;
          4'b1001: code = CODE_X;
          4'b1010: code = CODE_C;
          4'b1011: code = CODE_Y;
          4'b1100: code = CODE_Z;
          4'b1101: code = CODE_Q;
          default: code = CODE_NONE;
        endcase
      3'd5:
        case (bits)
          5'b11111: code = CODE_0;
          5'b01111: code = CODE_1;
          5'b00111: code = CODE_2;
          5'b00011: code = CODE_3;
          5'b00001: code = CODE_4;
          5'b00000: code = CODE_5;
          5'b10000: code = CODE_6;
          5'b11000: code = CODE_7;
          5'b11100: code = CODE_8;
          5'b11110: code = CODE_9;
          default: code = CODE_NONE;
        endcase
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_unit_counter.sv
// Tick-enabled saturating unit counter with synchronous clear; o_count_eff already
// includes the current cycle's tick so the caller can decide on it in the same cycle.
module morse_unit_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_count_eff
);

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat       = &r_count;
  assign o_count_eff = (i_tick && !w_sat) ? r_count + 1'b1 : r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else            r_count <= o_count_eff;
  end

endmodule

// File: rtl/morse_sequencer.sv
// Telegraph key to character code sequencer. Define MORSE_AUTOCLEAR_EN to blank the
// displayed code after CLEAR_UNITS idle ticks following a commit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no letter in progress, waiting for key
// ST_PRESS  | key held, counting press duration
// ST_GAP    | key released, counting idle ticks toward end of letter
// ST_COMMIT | decoded code presented with code_valid, buffer clears on exit
module morse_sequencer #(
  parameter int DASH_UNITS  = 2,
  parameter int GAP_UNITS   = 3,
  parameter int CLEAR_UNITS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       tick,
  output logic [5:0] state,
  output logic       code_valid,
  output logic       busy
);
  import morse_pkg::*;

  localparam int CNT_MAX = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_UNITS);

  if (DASH_UNITS < 1 || GAP_UNITS < 1 || CLEAR_UNITS < 1) begin : g_bad_param
    $error("morse_sequencer: unit parameters must be at least 1");
  end

  morse_state_e     r_fsm;
  logic [4:0]       r_bits;
  logic [2:0]       r_len;
  logic             r_ovf;
  logic [5:0]       r_state;
  logic             r_valid;
  logic             r_busy;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_clr;
  logic             w_gap_done;
  logic             w_is_dash;

`ifdef MORSE_AUTOCLEAR_EN
  localparam int CLR_W = $clog2(CLEAR_UNITS + 1);
  logic [CLR_W-1:0] r_clr_cnt;
  logic             r_clr_armed;
`endif

  assign w_gap_done = (w_cnt >= GAP_CNT);
  assign w_is_dash  = (w_cnt >= DASH_CNT);

  // counter restarts on every state entry so a tick on the exit cycle stays with the old state
  always_comb begin
    w_cnt_clr = 1'b1;
    case (r_fsm)
      ST_PRESS: w_cnt_clr = !key;
      ST_GAP:   w_cnt_clr = key || w_gap_done;
      default:  w_cnt_clr = 1'b1;
    endcase
  end

  morse_unit_counter #(.WIDTH(CNT_W)) u_unit_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_cnt_clr),
    .i_tick      (tick),
    .o_count_eff (w_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm       <= ST_IDLE;
      r_bits      <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      r_state     <= CODE_NONE;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MORSE_AUTOCLEAR_EN
      r_clr_cnt   <= '0;
      r_clr_armed <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        ST_IDLE:
          if (key) begin
            r_fsm  <= ST_PRESS;
            r_busy <= 1'b1;
          end
        ST_PRESS:
          if (!key) begin
            r_fsm <= ST_GAP;
            if (r_len == 3'd5) begin
              r_ovf <= 1'b1;
            end else begin
              r_bits <= {r_bits[3:0], w_is_dash};
              r_len  <= r_len + 3'd1;
            end
          end
        ST_GAP:
          if (key) begin
            r_fsm <= ST_PRESS;
          end else if (w_gap_done) begin
            r_fsm   <= ST_COMMIT;
            r_state <= r_ovf ? CODE_NONE : morse_decode(r_len, r_bits);
            r_valid <= 1'b1;
          end
        ST_COMMIT: begin
          r_fsm  <= ST_IDLE;
          r_busy <= 1'b0;
          r_bits <= '0;
          r_len  <= '0;
          r_ovf  <= 1'b0;
        end
        default: begin
          r_fsm  <= ST_IDLE;
          r_busy <= 1'b0;
        end
      endcase
`ifdef MORSE_AUTOCLEAR_EN
      if (r_fsm == ST_GAP && !key && w_gap_done) begin
        r_clr_armed <= 1'b1;
        r_clr_cnt   <= '0;
      end else if (r_fsm != ST_IDLE || key) begin
        r_clr_cnt <= '0;
      end else if (r_clr_armed && tick) begin
        if (r_clr_cnt == CLR_W'(CLEAR_UNITS - 1)) begin
          r_state     <= CODE_NONE;
          r_clr_armed <= 1'b0;
          r_clr_cnt   <= '0;
        end else begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
        end
      end
`endif
    end
  end

  assign state      = r_state;
  assign code_valid = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: letters push their expected code, a monitor
// pops and compares on every code_valid pulse.
module tb_morse_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic       tick;
  logic [5:0] state;
  logic       code_valid;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_code;

  localparam logic [5:0] NONE = 6'b111111;

  morse_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .tick       (tick),
    .state      (state),
    .code_valid (code_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && code_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: state=%0d, expected no commit", state);
      end else begin
        exp_code = exp_q.pop_front();
        chk("commit_code", int'(state), int'(exp_code));
      end
    end
  end

  // one Morse unit: two quiet cycles, then a one-cycle tick
  task automatic unit();
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press(input int n);
    key = 1'b1;
    repeat (n) unit();
    key = 1'b0;
  endtask

  task automatic gap(input int n);
    key = 1'b0;
    repeat (n) unit();
  endtask

  task automatic finish_letter();
    gap(3);
    chk("commit_latency", int'(code_valid), 1);
    @(negedge clk);
    chk("valid_pulse_width", int'(code_valid), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input string pat, input logic [5:0] exp);
    exp_q.push_back(exp);
    for (int i = 0; i < pat.len(); i++) begin
      press((pat[i] == "-") ? 3 : 1);
      if (i != pat.len() - 1) gap(1);
    end
    finish_letter();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    key   = 1'b0;
    tick  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), int'(NONE));
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(code_valid), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    send(".-", 6'd10);
    chk("busy_after_letter", int'(busy), 0);
    send("-----", 6'd0);
    send("----.", 6'd9);
    send("......", NONE);
    send(".", 6'd14);

    // key rises on the tick that would end the gap: key wins, same letter
    exp_q.push_back(6'd28);
    press(1); gap(1); press(1); gap(2);
    repeat (2) @(negedge clk);
    tick = 1'b1;
    key  = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("busy_in_press", int'(busy), 1);
    unit();
    key = 1'b0;
    finish_letter();

    // reset mid-press after two elements discards the partial letter
    press(1); gap(1); press(3); gap(1);
    key = 1'b1;
    unit();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_reset_state", int'(state), int'(NONE));
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_valid", int'(code_valid), 0);
    key = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send("-", 6'd29);

    // tick coinciding with release counts toward the press: 2 units -> dash, giving N
    exp_q.push_back(6'd23);
    key = 1'b1;
    unit();
    repeat (2) @(negedge clk);
    tick = 1'b1;
    key  = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    gap(1);
    press(1);
    finish_letter();

    send(".", 6'd14);
    repeat (14) unit();
    chk("hold_before_clear", int'(state), 14);
    unit();
`ifdef MORSE_AUTOCLEAR_EN
    chk("autoclear_state", int'(state), int'(NONE));
`else
    chk("hold_no_autoclear", int'(state), 14);
`endif
    repeat (3) unit();
    chk("valid_idle_low", int'(code_valid), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 The block SHALL have parameter DASH_UNITS, default 2, meaning the minimum press length in ticks that is classified as a dash.
REQ-002 The block SHALL have parameter GAP_UNITS, default 3, meaning the number of idle ticks that ends a letter.
REQ-003 The block SHALL have parameter CLEAR_UNITS, default 15, meaning the number of idle ticks after a commit before auto-clear (used only with the macro of REQ-021).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; it is asynchronous and active-low.
REQ-006 The block SHALL have port key, input, 1 bit, the debounced and synchronized telegraph key; 1 means pressed.
REQ-007 The block SHALL have port tick, input, 1 bit, a one-cycle timebase strobe with one pulse per Morse unit.
REQ-008 The block SHALL have port state, output, 6 bits, the character code that drives the display decoder.
REQ-009 The block SHALL have port code_valid, output, 1 bit, a one-cycle pulse when state is updated by a commit.
REQ-010 The block SHALL have port busy, output, 1 bit, asserted high whenever the FSM is not in IDLE.

Function
REQ-011 The character encoding SHALL be: digits 0-9 map to codes 0-9; letters A-Z map to codes 10-35; 6'b111111 means error or none (the display shows its default pattern).
REQ-012 The FSM states SHALL be IDLE, PRESS, GAP and COMMIT.
- IDLE goes to PRESS when key=1.
- PRESS goes to GAP when key=0, appending one element.
- GAP goes to PRESS when key=1.
- GAP goes to COMMIT when the gap count reaches GAP_UNITS.
- COMMIT goes to IDLE after one cycle.
REQ-013 In PRESS, a duration counter SHALL increment on each tick and saturate at its maximum; on key release the element is a dash if the count is at least DASH_UNITS, otherwise a dot.
REQ-014 The element buffer SHALL hold up to 5 elements, MSB-first (1 = dash), with a 3-bit length; a 6th element SHALL set a sticky overflow flag and is not stored.
REQ-015 In COMMIT, state SHALL load the decoded code, or 6'b111111 if overflow is set or the pattern is not in the table; code_valid SHALL pulse in the same cycle; the buffer, length and overflow flag SHALL then clear.
REQ-016 Commit latency SHALL be exactly 1 clk cycle after the tick that brings the gap count to GAP_UNITS.
REQ-017 If key=1 in the same cycle that the gap count would reach GAP_UNITS, key SHALL win: the FSM goes to PRESS, there is no commit, and the element joins the same letter.
REQ-018 A tick arriving in the same cycle as a key transition SHALL be counted in the state being exited.
REQ-019 state SHALL hold its value between commits; code_valid SHALL be 0 in every cycle other than a commit.

Reset
REQ-020 While reset=0 the block SHALL immediately force: state=6'b111111, code_valid=0, busy=0, FSM=IDLE, and all counters, buffer, length and overflow flag cleared; this applies mid-press and mid-gap, and the partial letter is discarded.

Configuration
REQ-021 With macro MORSE_AUTOCLEAR_EN defined, state SHALL return to 6'b111111 after CLEAR_UNITS ticks of continuous IDLE following a commit, without a code_valid pulse; any key press restarts this wait.
REQ-022 With MORSE_AUTOCLEAR_EN undefined, state SHALL hold until the next commit or reset, and no clear counter SHALL exist.

Structure
REQ-023 A package morse_pkg SHALL hold the FSM state enum, the CODE_NONE=6'b111111 constant, the code constants for 0-9 and A-Z, and the decode function mapping (length, bits) to a 6-bit code.
REQ-024 The duration/gap counter SHALL be a sub-module, morse_unit_counter (tick-enabled, saturating, synchronous clear); the display decoder SHALL remain a separate instance outside this block.

Verification
REQ-025 Scenario A: press 1 tick, release, press 3 ticks, release, idle 3 ticks -> code_valid pulses once, state=10 (A).
REQ-026 Scenario zero: five presses of 3 ticks each separated by 1-tick gaps, then idle 3 ticks -> state=0; then four dashes followed by one dot (dash-dash-dash-dash-dot) -> state=9.
REQ-027 Scenario overflow: six dots, then idle -> state=6'b111111 with a code_valid pulse; the next letter E (one dot) -> state=14.
REQ-028 Scenario collision: key rises on the same tick that the gap count reaches 3 -> no commit; dot, dot (simultaneous press), dot -> state=28 (S).
REQ-029 Scenario reset: reset=0 mid-PRESS after 2 elements -> state=6'b111111 and busy=0 immediately; after release, a lone dash -> state=29 (T).
REQ-030 Scenario autoclear (MORSE_AUTOCLEAR_EN defined): commit E, then 15 idle ticks -> state=6'b111111 with no code_valid pulse; with the macro undefined, state stays 14.
